// File: rtl/lane_unpacker.sv
// lane_unpacker: accepts a DATA_W-bit word and returns one selected lane, or
// every lane in ascending order, zero- or sign-extended to OUT_W. Valid/ready
// on both sides; the output beat is registered.
module lane_unpacker #(
  parameter int DATA_W = 32,
  parameter int LANE_W = 8,
  parameter int OUT_W  = 32,
  localparam int LANES = DATA_W / LANE_W,
  localparam int SEL_W = $clog2(LANES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic              out_err
);

  // Elaboration-time guard against unsupported geometry.
  if ((DATA_W % LANE_W) != 0 || OUT_W < LANE_W) begin : g_param_check
    $fatal(1, "lane_unpacker: DATA_W must be a multiple of LANE_W and OUT_W >= LANE_W");
  end

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                signed_q, signed_d;
  logic [SEL_W-1:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0]    out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic                out_err_q, out_err_d;
  logic                accept;
  logic                handshake;

  function automatic logic [LANE_W-1:0] pick_lane(input logic [DATA_W-1:0] d,
                                                  input logic [SEL_W-1:0]  idx);
    pick_lane = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (idx == SEL_W'(l)) pick_lane = d[l*LANE_W +: LANE_W];
    end
  endfunction

  function automatic logic [OUT_W-1:0] extend(input logic [LANE_W-1:0] lane,
                                              input logic              sgn);
    extend = {OUT_W{sgn & lane[LANE_W-1]}};
    extend[LANE_W-1:0] = lane;
  endfunction

  // out_valid is the EMIT state itself, so an async reset drops it at once.
  assign out_valid = (state_q == EMIT);
  assign in_ready  = rst_n && (!out_valid || (out_ready && out_last_q));
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_err   = out_err_q;

  // Next-state, holding registers and next output beat.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    sel_d      = sel_q;
    signed_d   = signed_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    out_err_d  = out_err_q;
    // A new accept takes priority: it can coincide with the final handshake,
    // in which case the FSM simply stays in EMIT with the new first beat.
    if (accept) begin
      state_d  = EMIT;
      data_d   = in_data;
      sel_d    = in_sel;
      signed_d = in_signed;
      cnt_d    = '0;
      if (in_sel == '0) begin
        out_data_d = extend(pick_lane(in_data, '0), in_signed);
        out_last_d = (LANES == 1);
        out_err_d  = 1'b0;
      end else if (in_sel > SEL_W'(LANES)) begin
        out_data_d = '0;
        out_last_d = 1'b1;
        out_err_d  = 1'b1;
      end else begin
        out_data_d = extend(pick_lane(in_data, in_sel - SEL_W'(1)), in_signed);
        out_last_d = 1'b1;
        out_err_d  = 1'b0;
      end
    end else if (handshake) begin
      if (out_last_q) begin
        state_d = IDLE;
      end else if (sel_q == '0) begin
        cnt_d      = cnt_q + SEL_W'(1);
        out_data_d = extend(pick_lane(data_q, cnt_d), signed_q);
        out_last_d = (cnt_d == SEL_W'(LANES - 1));
        out_err_d  = 1'b0;
      end
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      data_q     <= '0;
      sel_q      <= '0;
      signed_q   <= 1'b0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      sel_q      <= sel_d;
      signed_q   <= signed_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      out_err_q  <= out_err_d;
    end
  end

endmodule

// File: tb/tb_lane_unpacker.sv
// Scoreboard bench for lane_unpacker: byte-lane and halfword-lane instances.
module tb_lane_unpacker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, in_signed;
  logic [31:0] in_data;
  logic [2:0]  in_sel;
  logic        out_valid, out_ready, out_last, out_err;
  logic [31:0] out_data;

  logic        h_in_valid, h_in_ready, h_in_signed;
  logic [31:0] h_in_data;
  logic [1:0]  h_in_sel;
  logic        h_out_valid, h_out_ready, h_out_last, h_out_err;
  logic [31:0] h_out_data;

  lane_unpacker #(.DATA_W(32), .LANE_W(8), .OUT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_err(out_err)
  );

  lane_unpacker #(.DATA_W(32), .LANE_W(16), .OUT_W(32)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(h_in_valid), .in_ready(h_in_ready), .in_data(h_in_data),
    .in_sel(h_in_sel), .in_signed(h_in_signed),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .out_data(h_out_data),
    .out_last(h_out_last), .out_err(h_out_err)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        err;
  } beat_t;

  beat_t exp_q[$];
  beat_t hexp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;

  // Cycle counter used for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic l, input logic e);
    beat_t b;
    b.data = d; b.last = l; b.err = e;
    exp_q.push_back(b);
  endtask

  task automatic hexpect_beat(input logic [31:0] d, input logic l, input logic e);
    beat_t b;
    b.data = d; b.last = l; b.err = e;
    hexp_q.push_back(b);
  endtask

  // Byte-lane monitor: pop and compare on every output handshake.
  always @(negedge clk) begin : mon8
    beat_t e;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_beat: got 0x%08h, expected no beat", out_data);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", out_data, e.data);
        check("beat_last", {31'b0, out_last}, {31'b0, e.last});
        check("beat_err",  {31'b0, out_err},  {31'b0, e.err});
      end
    end
  end

  // Halfword-lane monitor.
  always @(negedge clk) begin : mon16
    beat_t e;
    if (h_out_valid && h_out_ready) begin
      if (hexp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL h_unexpected_beat: got 0x%08h, expected no beat", h_out_data);
      end else begin
        e = hexp_q.pop_front();
        check("h_beat_data", h_out_data, e.data);
        check("h_beat_last", {31'b0, h_out_last}, {31'b0, e.last});
        check("h_beat_err",  {31'b0, h_out_err},  {31'b0, e.err});
      end
    end
  end

  // Present a request and hold it until accepted; returns 1 time unit after
  // the accepting edge.
  task automatic send(input logic [31:0] d, input logic [2:0] s, input logic sg);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_sel = s; in_signed = sg;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got in_ready=0, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_data = 32'hDEADBEEF; in_sel = 3'd6; in_signed = 1'b1;
  endtask

  task automatic hsend(input logic [31:0] d, input logic [1:0] s, input logic sg);
    int n = 0;
    h_in_valid = 1'b1; h_in_data = d; h_in_sel = s; h_in_signed = sg;
    @(negedge clk);
    while (!h_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!h_in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL h_accept_timeout: got in_ready=0, expected 1");
    end
    @(posedge clk);
    #1;
    h_in_valid = 1'b0; h_in_data = 32'hDEADBEEF;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || hexp_q.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0 || hexp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d beats outstanding, expected 0",
               exp_q.size() + hexp_q.size());
    end
  endtask

  int c1, c2;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_sel = '0; in_signed = 1'b0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_in_data = '0; h_in_sel = '0; h_in_signed = 1'b0; h_out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_last", {31'b0, out_last}, 32'd0);
    check("rst_out_err", {31'b0, out_err}, 32'd0);
    check("rst_h_out_valid", {31'b0, h_out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // 1: single lane, zero-extend, one-cycle latency
    expect_beat(32'h000000C3, 1'b1, 1'b0);
    send(32'hA1B2C3D4, 3'd2, 1'b0);
    check("t1_valid_after_accept", {31'b0, out_valid}, 32'd1);
    check("t1_data", out_data, 32'h000000C3);
    drain();

    // 2: sign extension, plus zero-extend of a negative lane and sign-extend of a positive one
    expect_beat(32'hFFFFFFA1, 1'b1, 1'b0);
    send(32'hA1B2C3D4, 3'd4, 1'b1);
    expect_beat(32'hFFFFFFD4, 1'b1, 1'b0);
    send(32'hA1B2C3D4, 3'd1, 1'b1);
    expect_beat(32'hFFFFFFB2, 1'b1, 1'b0);
    send(32'hA1B2C3D4, 3'd3, 1'b1);
    expect_beat(32'h000000A1, 1'b1, 1'b0);
    send(32'hA1B2C3D4, 3'd4, 1'b0);
    expect_beat(32'h00000033, 1'b1, 1'b0);
    send(32'h11223344, 3'd2, 1'b1);
    drain();

    // 3: stream with backpressure on beat 2
    expect_beat(32'h000000D4, 1'b0, 1'b0);
    expect_beat(32'h000000C3, 1'b0, 1'b0);
    expect_beat(32'h000000B2, 1'b0, 1'b0);
    expect_beat(32'h000000A1, 1'b1, 1'b0);
    send(32'hA1B2C3D4, 3'd0, 1'b0);
    check("t3_in_ready_beat0", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("t3_stall_data", out_data, 32'h000000C3);
      check("t3_stall_valid", {31'b0, out_valid}, 32'd1);
      check("t3_stall_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t3_in_ready_beat2", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("t3_final_last", {31'b0, out_last}, 32'd1);
    check("t3_final_in_ready", {31'b0, in_ready}, 32'd1);
    drain();

    // 4: back-to-back, new request accepted on the final stream beat
    expect_beat(32'h0000000D, 1'b0, 1'b0);
    expect_beat(32'hFFFFFFF0, 1'b0, 1'b0);
    expect_beat(32'hFFFFFFFE, 1'b0, 1'b0);
    expect_beat(32'hFFFFFFCA, 1'b1, 1'b0);
    send(32'hCAFEF00D, 3'd0, 1'b1);
    c1 = cyc;
    expect_beat(32'h00000044, 1'b1, 1'b0);
    send(32'h11223344, 3'd1, 1'b0);
    c2 = cyc;
    check("t4_no_bubble_cycles", c2 - c1, 32'd4);
    check("t4_valid", {31'b0, out_valid}, 32'd1);
    check("t4_data", out_data, 32'h00000044);
    drain();

    // 5: out-of-range select
    expect_beat(32'h00000000, 1'b1, 1'b1);
    send(32'hA1B2C3D4, 3'd5, 1'b0);
    check("t5_err", {31'b0, out_err}, 32'd1);
    @(posedge clk);
    #1;
    check("t5_idle_valid", {31'b0, out_valid}, 32'd0);
    check("t5_idle_in_ready", {31'b0, in_ready}, 32'd1);
    expect_beat(32'h00000000, 1'b1, 1'b1);
    send(32'hFFFFFFFF, 3'd7, 1'b1);
    drain();

    // 6: reset mid-stream after beat 2
    expect_beat(32'h000000D4, 1'b0, 1'b0);
    expect_beat(32'h000000C3, 1'b0, 1'b0);
    expect_beat(32'h000000B2, 1'b0, 1'b0);
    expect_beat(32'h000000A1, 1'b1, 1'b0);
    send(32'hA1B2C3D4, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", {31'b0, out_valid}, 32'd0);
    check("t6_async_data", out_data, 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("t6_no_more_beats", {31'b0, out_valid}, 32'd0);

    // 7: halfword lanes, sign-extended stream
    hexpect_beat(32'hFFFFF00F, 1'b0, 1'b0);
    hexpect_beat(32'hFFFF8001, 1'b1, 1'b0);
    hsend(32'h8001F00F, 2'd0, 1'b1);
    check("t7_first_data", h_out_data, 32'hFFFFF00F);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
